// File: rtl/bp_me_pkg.sv
// Shared types and width helpers for the memory-command arbiter and its tag FIFO.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_arb_req_icache = 1'b0,
        e_arb_req_dcache = 1'b1
    } bp_me_arb_req_e;

    localparam int unsigned bp_me_arb_num_req_gp = 2;

    typedef enum int {
        e_bp_default_cfg = 0,
        e_bp_small_cfg   = 1
    } bp_params_e;

    typedef struct packed {
        int unsigned paddr_width;
        int unsigned block_width;
        int unsigned lce_id_width;
    } bp_proc_param_s;

    localparam int unsigned mem_msg_type_width_gp = 4;
    localparam int unsigned mem_msg_size_width_gp = 3;

    function automatic bp_proc_param_s bp_get_params(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_small_cfg: p = '{paddr_width: 32, block_width: 128, lce_id_width: 2};
            default:        p = '{paddr_width: 40, block_width: 512, lce_id_width: 4};
        endcase
        return p;
    endfunction

    // Header (type, size, address, LCE id) followed by one cache block of payload.
    function automatic int unsigned bp_cce_mem_msg_width(bp_params_e cfg);
        bp_proc_param_s p;
        p = bp_get_params(cfg);
        return mem_msg_type_width_gp + mem_msg_size_width_gp
             + p.paddr_width + p.lce_id_width + p.block_width;
    endfunction

    function automatic logic [31:0] sat_inc32(logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_me_mem_arb_tag_fifo.sv
// In-order FIFO of 1-bit requester tags; records who owns each in-flight memory command.
module bp_me_mem_arb_tag_fifo
    import bp_me_pkg::*;
#(
    parameter int unsigned els_p = 4
)
(
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           push_i,
    input  bp_me_arb_req_e data_i,
    input  logic           pop_i,
    output bp_me_arb_req_e data_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [els_p-1:0]    mem_q, mem_d;
    logic                push_ok, pop_ok;

    assign full_o  = (cnt_q == full_cnt_lp);
    assign empty_o = (cnt_q == '0);
    assign data_o  = bp_me_arb_req_e'(mem_q[rptr_q]);

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        if (push_ok) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
        end
        if (pop_ok) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: tag storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Two-requester round-robin memory command arbiter with in-order response routing.
// Optional statistics counters are built only when BP_ME_MEM_ARB_STATS_EN is defined.
module bp_me_mem_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter bp_params_e  bp_params_p       = e_bp_default_cfg,
    parameter int unsigned outstanding_els_p = 4,
    localparam int unsigned cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
)
(
    input  logic                                                       clk_i,
    input  logic                                                       reset_n_i,

    input  logic [bp_me_arb_num_req_gp-1:0][cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic [bp_me_arb_num_req_gp-1:0]                            mem_cmd_v_i,
    output logic [bp_me_arb_num_req_gp-1:0]                            mem_cmd_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0]                            mem_cmd_o,
    output logic                                                       mem_cmd_v_o,
    input  logic                                                       mem_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0]                            mem_resp_i,
    input  logic                                                       mem_resp_v_i,
    output logic                                                       mem_resp_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0]                            mem_resp_o,
    output logic [bp_me_arb_num_req_gp-1:0]                            mem_resp_v_o,
    input  logic [bp_me_arb_num_req_gp-1:0]                            mem_resp_yumi_i,

    output logic                                                       err_o,
    output logic [bp_me_arb_num_req_gp-1:0][31:0]                      grant_cnt_o,
    output logic [31:0]                                                conflict_cnt_o
);

    bp_me_arb_req_e last_grant_q, last_grant_d, grant_idx, head;
    logic           err_q, err_d;
    logic           both_v, grant, resp_pop, fifo_full, fifo_empty;

    bp_me_mem_arb_tag_fifo #(.els_p(outstanding_els_p)) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (grant),
        .data_i    (grant_idx),
        .pop_i     (resp_pop),
        .data_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Reset gates the grant so command outputs drop as soon as reset asserts.
    always_comb begin
        both_v = &mem_cmd_v_i;
        if (both_v) begin
            grant_idx = bp_me_arb_req_e'(~last_grant_q);
        end else if (mem_cmd_v_i[e_arb_req_dcache]) begin
            grant_idx = e_arb_req_dcache;
        end else begin
            grant_idx = e_arb_req_icache;
        end
        grant                     = reset_n_i & mem_cmd_ready_i & ~fifo_full & (|mem_cmd_v_i);
        mem_cmd_yumi_o            = '0;
        mem_cmd_yumi_o[grant_idx] = grant;
        mem_cmd_v_o               = grant;
        mem_cmd_o                 = mem_cmd_i[grant_idx];
        last_grant_d              = grant ? grant_idx : last_grant_q;
    end

    always_comb begin
        mem_resp_o         = mem_resp_i;
        mem_resp_v_o       = '0;
        mem_resp_v_o[head] = mem_resp_v_i & ~fifo_empty;
        resp_pop           = mem_resp_yumi_i[head] & mem_resp_v_o[head];
        mem_resp_yumi_o    = resp_pop;
        err_d = err_q
              | (mem_resp_v_i & fifo_empty)
              | (|(mem_resp_yumi_i & ~mem_resp_v_o));
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= e_arb_req_dcache;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

`ifdef BP_ME_MEM_ARB_STATS_EN
    logic [bp_me_arb_num_req_gp-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]                           conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant) begin
            grant_cnt_d[grant_idx] = sat_inc32(grant_cnt_q[grant_idx]);
        end
        if (grant & both_v) begin
            conflict_cnt_d = sat_inc32(conflict_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt_o    = grant_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign grant_cnt_o    = '0;
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed, table-driven bench for bp_me_mem_cmd_arbiter (default config, 4 outstanding).
module tb_bp_me_mem_cmd_arbiter;
    import bp_me_pkg::*;

    localparam int unsigned W     = bp_cce_mem_msg_width(e_bp_default_cfg);
    localparam int unsigned N_VEC = 26;

    typedef struct packed {
        logic [1:0] v;
        logic       rdy;
        logic       rv;
        logic [1:0] ry;
        logic [1:0] e_yumi;
        logic [1:0] e_rvo;
        logic       e_ryo;
        logic       e_err;
    } vec_t;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i;
    logic [1:0][W-1:0]     mem_cmd_i;
    logic [1:0]            mem_cmd_v_i;
    logic [1:0]            mem_cmd_yumi_o;
    logic [W-1:0]          mem_cmd_o;
    logic                  mem_cmd_v_o;
    logic                  mem_cmd_ready_i;
    logic [W-1:0]          mem_resp_i;
    logic                  mem_resp_v_i;
    logic                  mem_resp_yumi_o;
    logic [W-1:0]          mem_resp_o;
    logic [1:0]            mem_resp_v_o;
    logic [1:0]            mem_resp_yumi_i;
    logic                  err_o;
    logic [1:0][31:0]      grant_cnt_o;
    logic [31:0]           conflict_cnt_o;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [N_VEC];

    always #5 clk_i = ~clk_i;

    bp_me_mem_cmd_arbiter #(
        .bp_params_p       (e_bp_default_cfg),
        .outstanding_els_p (4)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_yumi_o  (mem_cmd_yumi_o),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .err_o           (err_o),
        .grant_cnt_o     (grant_cnt_o),
        .conflict_cnt_o  (conflict_cnt_o)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic [1:0] v, input logic rdy, input logic rv,
                                 input logic [1:0] ry, input logic [1:0] e_yumi,
                                 input logic [1:0] e_rvo, input logic e_ryo, input logic e_err);
        vec_t r;
        r = '{v: v, rdy: rdy, rv: rv, ry: ry, e_yumi: e_yumi,
              e_rvo: e_rvo, e_ryo: e_ryo, e_err: e_err};
        return r;
    endfunction

    task automatic drive_idle();
        mem_cmd_v_i     = 2'b00;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b0;
        mem_resp_yumi_i = 2'b00;
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, state moves at the next rise.
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk_i);
        mem_cmd_v_i     = t.v;
        mem_cmd_ready_i = t.rdy;
        mem_resp_v_i    = t.rv;
        mem_resp_yumi_i = t.ry;
        #1;
        check({tag, " cmd_yumi"},  W'(mem_cmd_yumi_o),  W'(t.e_yumi));
        check({tag, " cmd_v"},     W'(mem_cmd_v_o),     W'(|t.e_yumi));
        check({tag, " resp_v"},    W'(mem_resp_v_o),    W'(t.e_rvo));
        check({tag, " resp_yumi"}, W'(mem_resp_yumi_o), W'(t.e_ryo));
        check({tag, " err"},       W'(err_o),           W'(t.e_err));
        if (t.e_yumi != 2'b00)
            check({tag, " cmd_data"}, mem_cmd_o, t.e_yumi[1] ? mem_cmd_i[1] : mem_cmd_i[0]);
        if (t.e_rvo != 2'b00)
            check({tag, " resp_data"}, mem_resp_o, mem_resp_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_yumi"},  W'(mem_cmd_yumi_o),  W'(2'b00));
        check({tag, " cmd_v"},     W'(mem_cmd_v_o),     W'(1'b0));
        check({tag, " resp_v"},    W'(mem_resp_v_o),    W'(2'b00));
        check({tag, " resp_yumi"}, W'(mem_resp_yumi_o), W'(1'b0));
        check({tag, " err"},       W'(err_o),           W'(1'b0));
        check({tag, " grant_cnt0"}, W'(grant_cnt_o[0]), W'(0));
        check({tag, " grant_cnt1"}, W'(grant_cnt_o[1]), W'(0));
        check({tag, " conflict"},   W'(conflict_cnt_o), W'(0));
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_g0, exp_g1, exp_conf;

        mem_cmd_i[0] = {W{1'b1}} ^ W'(64'h0000_0000_0000_1234);
        mem_cmd_i[1] = W'(64'hC0DE_0000_0000_5678);
        mem_resp_i   = W'(64'h0000_0000_0000_AAAA);

        // Requests driven during reset must not leak through.
        reset_n_i       = 1'b0;
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        mem_resp_yumi_i = 2'b11;
        #2;
        check_reset_outputs("por");
        drive_idle();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;

        //            v     rdy   rv    ry     yumi   rvo    ryo   err
        tbl[0]  = row(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[1]  = row(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        tbl[2]  = row(2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0);
        tbl[3]  = row(2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
        tbl[4]  = row(2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0);
        tbl[5]  = row(2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0);
        tbl[6]  = row(2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0);
        tbl[7]  = row(2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        tbl[8]  = row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        tbl[9]  = row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        tbl[10] = row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        tbl[11] = row(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
        tbl[12] = row(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
        tbl[13] = row(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
        tbl[14] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        tbl[15] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        tbl[16] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        tbl[17] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        tbl[18] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[19] = row(2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        tbl[20] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        tbl[21] = row(2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tbl[22] = row(2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        tbl[23] = row(2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        tbl[24] = row(2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        tbl[25] = row(2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);

        for (int i = 0; i < N_VEC; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

`ifdef BP_ME_MEM_ARB_STATS_EN
        exp_g0 = 6; exp_g1 = 8; exp_conf = 6;
`else
        exp_g0 = 0; exp_g1 = 0; exp_conf = 0;
`endif
        check("stats grant_cnt0", W'(grant_cnt_o[0]), W'(exp_g0));
        check("stats grant_cnt1", W'(grant_cnt_o[1]), W'(exp_g1));
        check("stats conflict",   W'(conflict_cnt_o), W'(exp_conf));

        // Interleaved owners 0,1,1; the second response stalls until requester 1 takes it.
        apply(row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0), "ilv cmd0");
        apply(row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "ilv cmd1");
        apply(row(2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "ilv cmd2");
        mem_resp_i = W'(64'h0000_0000_0000_A0A0);
        apply(row(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0), "ilv respA");
        mem_resp_i = W'(64'h0000_0000_0000_B0B0);
        apply(row(2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0), "ilv stallB0");
        apply(row(2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0), "ilv stallB1");
        apply(row(2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0), "ilv respB");
        mem_resp_i = W'(64'h0000_0000_0000_C0C0);
        apply(row(2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0), "ilv respC");

        // Two tags for requester 0 in flight, then an asynchronous reset mid-cycle.
        apply(row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0), "fly0");
        apply(row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0), "fly1");
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        mem_resp_yumi_i = 2'b01;
        #1;
        check("prerst cmd_yumi", W'(mem_cmd_yumi_o), W'(2'b10));
        check("prerst resp_v",   W'(mem_resp_v_o),   W'(2'b01));
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        drive_idle();
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Empty after reset: a stray response routes nothing and makes err sticky.
        apply(row(2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), "post stray");
        apply(row(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1), "post conflict");
        apply(row(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "err hold0");
        apply(row(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "err hold1");

        do_reset();
        apply(row(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), "err cleared");

        // Yumi from the requester that does not own the head: error, head not popped.
        apply(row(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0), "wy cmd");
        apply(row(2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0), "wy wrong");
        apply(row(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1), "wy right");
        apply(row(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "wy idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
BP_ME_MEM_CMD_ARBITER -- requirements
Module: bp_me_mem_cmd_arbiter

Interface
REQ-001 Parameter bp_params_p, default e_bp_default_cfg, SHALL set paddr/block/lce widths and hence cce_mem_msg_width_lp.
REQ-002 Parameter outstanding_els_p, default 4, SHALL set the maximum number of in-flight commands; legal range 1..16.
REQ-003 Ports SHALL be clk_i, input, 1, sole clock; reset_n_i, input, 1, asynchronous active-low reset.
REQ-004 mem_cmd_i, input, 2 x cce_mem_msg_width_lp: command from requester 0 (I$ side) and requester 1 (D$/UCE side).
REQ-005 mem_cmd_v_i, input, 2: per-requester command valid.
REQ-006 mem_cmd_yumi_o, output, 2: per-requester command accepted this cycle.
REQ-007 mem_cmd_o, output, cce_mem_msg_width_lp; mem_cmd_v_o, output, 1; mem_cmd_ready_i, input, 1: memory-side command, ready-then-valid.
REQ-008 mem_resp_i, input, cce_mem_msg_width_lp; mem_resp_v_i, input, 1; mem_resp_yumi_o, output, 1: memory-side response, valid-yumi.
REQ-009 mem_resp_o, output, cce_mem_msg_width_lp (broadcast); mem_resp_v_o, output, 2; mem_resp_yumi_i, input, 2: per-requester response.
REQ-010 err_o, output, 1: sticky protocol error; grant_cnt_o, output, 2 x 32; conflict_cnt_o, output, 32: statistics.

Function
REQ-011 Command path SHALL be combinational (0-cycle latency); mem_cmd_o SHALL equal the granted requester's mem_cmd_i.
REQ-012 Grant SHALL be possible only when mem_cmd_ready_i=1 and tag FIFO not full; otherwise mem_cmd_v_o=0 and mem_cmd_yumi_o=0.
REQ-013 One requester valid: grant it. Both valid: grant the requester other than last_grant_r (round-robin).
REQ-014 last_grant_r SHALL update to the granted index on every grant and hold otherwise.
REQ-015 mem_cmd_v_o SHALL equal |mem_cmd_yumi_o; at most one yumi bit set per cycle; mem_cmd_ready_i SHALL NOT depend combinationally on mem_cmd_v_o.
REQ-016 Each grant SHALL push the granted index into an in-order tag FIFO; memory returns responses in command order.
REQ-017 Tag FIFO full SHALL block new grants even when a pop occurs in the same cycle; push and pop together when not full SHALL leave occupancy unchanged.
REQ-018 mem_resp_v_o[i] SHALL be mem_resp_v_i & FIFO non-empty & (head==i); mem_resp_yumi_o SHALL be mem_resp_yumi_i[head] & mem_resp_v_o[head], which also pops the FIFO.
REQ-019 A requester SHALL NOT see a response until yumi in the same or a later cycle; the head holds until yumi.
REQ-020 mem_resp_v_i=1 with an empty FIFO SHALL set err_o, route nothing, and leave mem_resp_yumi_o=0.
REQ-021 mem_resp_yumi_i[i] asserted with mem_resp_v_o[i]=0 SHALL set err_o and be ignored.
REQ-022 Occupancy counter SHALL be width $clog2(outstanding_els_p+1) and SHALL never wrap; read/write pointers SHALL wrap modulo outstanding_els_p.

Reset
REQ-023 While reset_n_i=0: FIFO empty, last_grant_r=1 (requester 0 wins first conflict), err_o=0, counters 0, all valid/yumi outputs 0.
REQ-024 Reset mid-operation SHALL discard in-flight tags; requesters and memory SHALL be reset together (no response recovery).

Configuration
REQ-025 With BP_ME_MEM_ARB_STATS_EN defined: grant_cnt_o[i] SHALL increment per grant to i; conflict_cnt_o SHALL increment per cycle with both valid and a grant; all counters saturate at 2^32-1.
REQ-026 Without BP_ME_MEM_ARB_STATS_EN: counter outputs SHALL be constant 0 and no counter flops SHALL be inferred; ports are unchanged.

Structure
REQ-027 bp_me_pkg SHALL hold the requester-index typedef bp_me_arb_req_e (e_arb_req_icache=0, e_arb_req_dcache=1) and the constant for the number of requesters (2).
REQ-028 Tag storage SHALL be a sub-module bp_me_mem_arb_tag_fifo (1-bit entries, outstanding_els_p deep, full/empty, async active-low reset); the arbiter proper holds grant logic, routing, error and stats.

Verification
REQ-029 Req0 alone sends 3 commands, ready=1 -> yumi0 on 3 consecutive cycles; 3 responses -> mem_resp_v_o=2'b01 each; FIFO returns to empty.
REQ-030 Both valid continuously, 6 cycles, ready=1, responses drained immediately -> grant order 0,1,0,1,0,1; conflict_cnt_o=6 with STATS_EN.
REQ-031 outstanding_els_p=4, no responses, 6 commands offered -> exactly 4 accepted; 5th yumi only on the cycle after the first response yumi.
REQ-032 Interleaved cmds 0,1,1 then responses A,B,C -> A to requester 0, B and C to requester 1; head stalls while mem_resp_yumi_i[1]=0.
REQ-033 mem_resp_v_i=1 with empty FIFO -> err_o=1 next cycle and stays 1 until reset; mem_resp_yumi_o=0.
REQ-034 reset_n_i driven low with 2 tags in flight, asynchronous to clk_i -> outputs 0 immediately; after release FIFO empty and requester 0 wins first conflict.
